// File: rtl/sar_ctrl_multi.sv
// Successive-approximation register controller with round-robin multi-channel scanning.
// Latency: result (data/data_ch/valid) SAMPLE_CYC + N*SETTLE_CYC cycles after the start edge.
// Backpressure: none; start is ignored while busy, en low aborts synchronously.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en, start, cont   block enable (low = abort/clear), conversion request, continuous mode
//   cmp               comparator decision (1 = keep the bit under trial)
//   sample, ch_sel    track switch and input mux select
//   dac_b, dac_bn     DAC switch word, true and complement
//   busy              high while sampling or converting
//   data, data_ch     last result and its channel, held until overwritten
//   valid             one-cycle strobe following each data update
module sar_ctrl_multi #(
    parameter int N          = 8,
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          cont,
    input  logic          cmp,
    output logic          sample,
    output logic [CW-1:0] ch_sel,
    output logic [N-1:0]  dac_b,
    output logic [N-1:0]  dac_bn,
    output logic          busy,
    output logic [N-1:0]  data,
    output logic [CW-1:0] data_ch,
    output logic          valid
);

    localparam int KW   = $clog2(N);
    localparam int CMAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNTW-1:0] SAMP_LAST = CNTW'(SAMPLE_CYC - 1);
    localparam logic [CNTW-1:0] SETL_LAST = CNTW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0]   K_MSB     = KW'(N - 1);
    localparam logic [CW-1:0]   CH_LAST   = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;        // shared: sample cycles in SAMPLE, settle cycles in CONV
    logic [KW-1:0]   k;          // bit currently under trial
    logic            samp_done;
    logic            decide;
    logic            last_bit;

    // Next-state and per-edge strobes. en low wins over everything else.
    always_comb begin
        state_nxt = state;
        samp_done = 1'b0;
        decide    = 1'b0;
        last_bit  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = SAMPLE;
                end
                SAMPLE: begin
                    if (cnt == SAMP_LAST) begin
                        samp_done = 1'b1;
                        state_nxt = CONV;
                    end
                end
                CONV: begin
                    if (cnt == SETL_LAST) begin
                        decide = 1'b1;
                        if (k == '0) begin
                            last_bit  = 1'b1;
                            state_nxt = cont ? SAMPLE : IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            k       <= '0;
            dac_b   <= '0;
            ch_sel  <= '0;
            data    <= '0;
            data_ch <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Abort: result registers are deliberately left untouched.
                cnt    <= '0;
                dac_b  <= '0;
                ch_sel <= '0;
            end else begin
                // Counter restarts at every phase boundary and whenever idle.
                if (samp_done || decide || state == IDLE) cnt <= '0;
                else                                      cnt <= cnt + 1'b1;

                if (samp_done) begin
                    dac_b        <= '0;
                    dac_b[N-1]   <= 1'b1;
                    k            <= K_MSB;
                end

                if (decide) begin
                    if (last_bit) begin
                        // Bit 0 decision folds straight into the result word.
                        data    <= {dac_b[N-1:1], cmp};
                        data_ch <= ch_sel;
                        valid   <= 1'b1;
                        ch_sel  <= (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
                        dac_b   <= '0;
                    end else begin
                        dac_b[k]        <= cmp;
                        dac_b[k - 1'b1] <= 1'b1;
                        k               <= k - 1'b1;
                    end
                end
            end
        end
    end

    assign sample = (state == SAMPLE);
    assign busy   = (state != IDLE);
    assign dac_bn = ~dac_b;

endmodule
